// File: rtl/if_fetch_unit.sv
// Instruction fetch: one outstanding imem request, in-order buffer of {insn, pc}, redirect with kill.
// Output lands one cycle after ack (no bypass); a full buffer stops requests until IF/ID consumes.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        LE,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic [31:0] instruction_out,
   output logic [31:0] pc_out,
   output logic        valid_out
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;
   localparam logic [1:0] ST_KILL  = 2'd3;

   logic [1:0]       state, state_nxt;
   logic [31:0]      pc, pc_nxt;
   logic [31:0]      target, target_nxt;
   logic [31:0]      target_aligned;
   logic [31:0]      buf_insn [FIFO_DEPTH];
   logic [31:0]      buf_pc   [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [CNT_W-1:0] count, count_nxt;
   logic             push, pop;

   assign target_aligned = {redirect_target[31:2], 2'b00};

   assign valid_out       = (count != '0);
   assign imem_req        = (state == ST_FETCH) || (state == ST_KILL);
   assign imem_addr       = pc;
   assign instruction_out = valid_out ? buf_insn[rd_ptr] : 32'h0;
   assign pc_out          = valid_out ? buf_pc[rd_ptr]   : 32'h0;

   // Redirect outranks both the returning word and the IF/ID consume.
   assign push = (state == ST_FETCH) && imem_ack && !redirect;
   assign pop  = LE && valid_out && !redirect;

   always_comb begin
      if (redirect) begin
         count_nxt = '0;
      end else begin
         count_nxt = count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc;
      target_nxt = target;
      case (state)
         ST_IDLE: begin
            state_nxt = ST_FETCH;
            if (redirect) begin
               pc_nxt = target_aligned;
            end
         end
         ST_FETCH: begin
            if (redirect) begin
               if (imem_ack) begin
                  pc_nxt    = target_aligned;
                  state_nxt = ST_FETCH;
               end else begin
                  // The pending request must complete before we may fetch the target.
                  target_nxt = target_aligned;
                  state_nxt  = ST_KILL;
               end
            end else if (imem_ack) begin
               pc_nxt    = pc + 32'd4;
               state_nxt = (count_nxt < DEPTH_C) ? ST_FETCH : ST_FULL;
            end
         end
         ST_FULL: begin
            if (redirect) begin
               pc_nxt    = target_aligned;
               state_nxt = ST_FETCH;
            end else if (count_nxt < DEPTH_C) begin
               state_nxt = ST_FETCH;
            end
         end
         ST_KILL: begin
            if (imem_ack) begin
               pc_nxt    = redirect ? target_aligned : target;
               state_nxt = ST_FETCH;
            end else if (redirect) begin
               target_nxt = target_aligned;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= ST_IDLE;
         pc     <= RESET_PC;
         target <= RESET_PC;
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         state  <= state_nxt;
         pc     <= pc_nxt;
         target <= target_nxt;
         count  <= count_nxt;
         if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (pop) begin
               rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (push) begin
               wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset && push) begin
         buf_insn[wr_ptr] <= imem_rdata;
         buf_pc[wr_ptr]   <= pc;
      end
   end

endmodule
